// File: rtl/pixel_pack_pkg.sv
// Shared types for the binarising pixel packer: capture FSM states and
// line geometry helpers.
package pixel_pack_pkg;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Packed bytes per line; a partial final byte still costs a whole byte.
    function automatic int bytes_per_line(input int img_w);
        return (img_w + 7) / 8;
    endfunction

endpackage

// File: rtl/thresh_shift8.sv
// Threshold compare plus 8-bit MSB-first packer with low-bit zero padding
// for bytes closed early at end of line or by a frame flush.
module thresh_shift8
    import pixel_pack_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pix,
    input  logic [11:0] thr,
    input  logic        take,
    input  logic        last_in_line,
    input  logic        flush,
    output logic        done,
    output logic [7:0]  byte_out
);

    logic [7:0] sr;
    logic [2:0] cnt;
    logic       bit_val;
    logic [7:0] shifted;

    assign bit_val = pix > thr;
    assign shifted = {sr[6:0], bit_val};

    // sr keeps collected bits right-aligned; completion left-aligns them.
    always_comb begin
        done     = 1'b0;
        byte_out = '0;
        if (take) begin
            if (cnt == 3'd7 || last_in_line) begin
                done     = 1'b1;
                byte_out = shifted << (3'd7 - cnt);
            end
        end else if (flush && cnt != 3'd0) begin
            done     = 1'b1;
            byte_out = sr << (4'd8 - {1'b0, cnt});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (take) begin
            if (done) begin
                sr  <= '0;
                cnt <= '0;
            end else begin
                sr  <= shifted;
                cnt <= cnt + 3'd1;
            end
        end else if (flush) begin
            sr  <= '0;
            cnt <= '0;
        end
    end

endmodule

// File: rtl/bin_pixel_packer.sv
// Binarises a raw pixel stream against a threshold and packs eight pixels
// per byte into a downstream FIFO, with a one-entry hold for back-pressure.
//
// state  | meaning
// SYNC   | wait for frame-valid low before trusting a frame start
// IDLE   | between frames, wait for frame-valid rising
// ACTIVE | accepting pixels; frame-valid low flushes and ends the frame
// DRAIN  | full frame captured, wait for frame-valid low
module bin_pixel_packer
    import pixel_pack_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [11:0] iDATA,
    input  logic        iDVAL,
    input  logic        iFVAL,
    input  logic [11:0] iThreshold,
    input  logic        iFULL,
    output logic [15:0] oDATA,
    output logic        oDVAL,
    output logic        oLINE_END,
    output logic        oFRAME_END,
    output logic        oOVF,
    output logic [15:0] oFrame_Cont
);

    localparam int PW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int LW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BPL = bytes_per_line(IMG_W);
    localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;

    state_t        state, state_nxt;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [BW-1:0] byte_idx;
    logic          take, flush, line_last, frame_last;
    logic          done, tag_le, tag_fe;
    logic [7:0]    byte_new;
    logic          hold_vld, hold_le, hold_fe;
    logic [7:0]    hold_byte;

    assign take       = (state == ST_ACTIVE) && iDVAL && iFVAL;
    assign flush      = (state == ST_ACTIVE) && !iFVAL;
    assign line_last  = pix_cnt == PW'(IMG_W - 1);
    assign frame_last = line_last && (line_cnt == LW'(IMG_H - 1));

    // A flushed byte always closes both the line and the frame.
    assign tag_le = flush ? 1'b1 : (byte_idx == BW'(BPL - 1));
    assign tag_fe = flush ? 1'b1 : frame_last;

    thresh_shift8 u_pack (
        .clk          (iCLK),
        .rst          (iRST),
        .pix          (iDATA),
        .thr          (iThreshold),
        .take         (take),
        .last_in_line (line_last),
        .flush        (flush),
        .done         (done),
        .byte_out     (byte_new)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_SYNC:   if (!iFVAL) state_nxt = ST_IDLE;
            ST_IDLE:   if (iFVAL) state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (flush)
                    state_nxt = ST_IDLE;
                else if (take && frame_last)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN:  if (!iFVAL) state_nxt = ST_SYNC;
            default:   state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST)
            state <= ST_SYNC;
        else
            state <= state_nxt;
    end

    always_ff @(posedge iCLK) begin
        if (iRST || flush) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            byte_idx <= '0;
        end else if (take) begin
            if (line_last) begin
                pix_cnt  <= '0;
                line_cnt <= frame_last ? '0 : line_cnt + LW'(1);
            end else begin
                pix_cnt <= pix_cnt + PW'(1);
            end
            if (done)
                byte_idx <= (byte_idx == BW'(BPL - 1)) ? '0 : byte_idx + BW'(1);
        end
    end

    // A byte completing while the hold slot is busy is lost, even if the
    // held byte leaves in the same cycle: the slot frees only afterwards.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oLINE_END   <= 1'b0;
            oFRAME_END  <= 1'b0;
            oOVF        <= 1'b0;
            oFrame_Cont <= '0;
            hold_vld    <= 1'b0;
            hold_byte   <= '0;
            hold_le     <= 1'b0;
            hold_fe     <= 1'b0;
        end else begin
            oDATA      <= '0;
            oDVAL      <= 1'b0;
            oLINE_END  <= 1'b0;
            oFRAME_END <= 1'b0;
            if (hold_vld) begin
                if (!iFULL) begin
                    oDATA      <= {8'h00, hold_byte};
                    oDVAL      <= 1'b1;
                    oLINE_END  <= hold_le;
                    oFRAME_END <= hold_fe;
                    hold_vld   <= 1'b0;
                    if (hold_fe)
                        oFrame_Cont <= oFrame_Cont + 16'd1;
                end
                if (done)
                    oOVF <= 1'b1;
            end else if (done) begin
                if (!iFULL) begin
                    oDATA      <= {8'h00, byte_new};
                    oDVAL      <= 1'b1;
                    oLINE_END  <= tag_le;
                    oFRAME_END <= tag_fe;
                    if (tag_fe)
                        oFrame_Cont <= oFrame_Cont + 16'd1;
                end else begin
                    hold_vld  <= 1'b1;
                    hold_byte <= byte_new;
                    hold_le   <= tag_le;
                    hold_fe   <= tag_fe;
                end
            end
        end
    end

endmodule

// File: doc/bin_pixel_packer.md
BIN_PIXEL_PACKER -- requirements
Module: bin_pixel_packer

Interface
REQ-001 Parameter IMG_W, default 640, active pixels per line.
REQ-002 Parameter IMG_H, default 480, active lines per frame.
REQ-003 iCLK  in  1  pixel clock; all logic SHALL be clocked on its rising edge only.
REQ-004 iRST  in  1  reset; synchronous, active-high.
REQ-005 iDATA  in  12  raw pixel value.
REQ-006 iDVAL  in  1  pixel-valid strobe for iDATA.
REQ-007 iFVAL  in  1  frame-valid level.
REQ-008 iThreshold  in  12  binarisation threshold.
REQ-009 iFULL  in  1  downstream write FIFO full; no write is accepted while high.
REQ-010 oDATA  out  16  packed word {8'h00, byte}, MSB = earliest pixel.
REQ-011 oDVAL  out  1  one-cycle write strobe for oDATA.
REQ-012 oLINE_END  out  1  high with the last byte of each line.
REQ-013 oFRAME_END  out  1  high with the last byte of each frame.
REQ-014 oOVF  out  1  sticky flag: a byte was dropped.
REQ-015 oFrame_Cont  out  16  count of completed frames, wraps at 16'hFFFF to 0.

Function
REQ-016 Pixel bit SHALL be 1 iff iDATA > iThreshold (unsigned, strict); iDATA == iThreshold gives 0.
REQ-017 FSM states SYNC, IDLE, ACTIVE, DRAIN; SYNC->IDLE when iFVAL=0; IDLE->ACTIVE when iFVAL=1; ACTIVE->DRAIN after pixel IMG_W*IMG_H is accepted; DRAIN->SYNC->IDLE path when iFVAL=0.
REQ-018 Pixels SHALL be accepted only in ACTIVE with iDVAL=1; iDVAL in any other state SHALL be ignored.
REQ-019 Each accepted bit SHALL shift into an 8-bit packer, MSB first; a pixel counter (0..IMG_W-1) and line counter (0..IMG_H-1) SHALL advance per accepted pixel, wrapping the pixel counter at IMG_W.
REQ-020 On the 8th bit, or on the last pixel of a line with a partial byte, the byte SHALL complete, zero-padded in the low bits; bytes per line = ceil(IMG_W/8).
REQ-021 A completed byte SHALL appear on oDATA with oDVAL=1 the cycle after the completing pixel if iFULL=0 and the hold register is empty (latency 1).
REQ-022 If iFULL=1 at completion, the byte (with its LINE_END/FRAME_END tags) SHALL go to a 1-entry hold register and be emitted in the first cycle with iFULL=0.
REQ-023 A byte completing while the hold register is occupied SHALL be dropped and oOVF set; the held byte is kept; oOVF clears only on reset.
REQ-024 iFVAL falling in ACTIVE (short frame) SHALL flush any partial byte with oLINE_END=oFRAME_END=1 in that byte and return to IDLE; with no partial byte, no extra strobe is emitted and oFRAME_END rides on no byte.
REQ-025 oFrame_Cont SHALL increment in the cycle oFRAME_END is emitted with oDVAL=1.
REQ-026 oDVAL, oLINE_END, oFRAME_END SHALL be 0 in every cycle without an emitted byte; oDATA[15:8] SHALL always be 0.

Reset
REQ-027 iRST=1 SHALL override all other inputs: state SYNC, counters, packer, hold register cleared.
REQ-028 Outputs after reset: oDATA=0, oDVAL=0, oLINE_END=0, oFRAME_END=0, oOVF=0, oFrame_Cont=0.
REQ-029 Reset mid-frame SHALL discard the partial frame; capture resumes only after an iFVAL low-to-high sequence.

Structure
REQ-030 Shared package pixel_pack_pkg SHALL hold the FSM state enum and a bytes-per-line derivation from IMG_W.
REQ-031 One sub-module, thresh_shift8, SHALL hold the threshold compare, 8-bit packer, bit counter and padding logic.

Verification
REQ-032 IMG_W=16, IMG_H=2, iThreshold=12'h800, pixels alternate 12'hFFF/12'h000 -> four bytes 8'hAA, oLINE_END on bytes 2 and 4, oFRAME_END on byte 4, oFrame_Cont=1.
REQ-033 IMG_W=12, all pixels 12'hFFF -> per line 16'h00FF then 16'h00F0, oLINE_END on 8'hF0.
REQ-034 iFULL=1 across one completion -> byte emitted 1 cycle after iFULL falls; iFULL=1 across two completions -> second byte dropped, oOVF=1.
REQ-035 iFVAL falls after three pixels of 12'hFFF -> one byte 8'hE0 with oLINE_END=oFRAME_END=1, state IDLE.
REQ-036 iRST mid-line, then iFVAL held high -> no oDVAL until iFVAL goes 0 then 1; iDATA=iThreshold -> 0 bit, iThreshold+1 -> 1 bit.
